// File: rtl/uart_rx_if.sv
// UART receiver signal bundle: serial input plus received-byte outputs.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  // Line driver / byte consumer side.
  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection and break handling.
// OVERSAMPLE must be even and >= 4.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic     clk1,
  input logic     rstn,
  uart_rx_if.slave bus
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_sync1, r_rx_s;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_bit_idx, w_bit_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic [7:0]      r_data, w_data_d;
  logic            r_valid, w_valid_d;
  logic            r_frame_err, w_frame_err_d;

  logic            w_cnt_wrap;
  logic            w_cnt_half;
  logic            w_bit_term;

  assign w_cnt_wrap = (r_cnt == CntMax);
  assign w_cnt_half = (r_cnt == CntHalf);
  // Terminal flag: the bit about to be sampled is bit 7, so the index never advances past it.
  assign w_bit_term = (r_bit_idx == 3'd7);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state, counters, shift register and output pulses.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_bit_idx_d   = r_bit_idx;
    w_shift_d     = r_shift;
    w_data_d      = r_data;
    w_valid_d     = 1'b0;
    w_frame_err_d = 1'b0;

    case (r_state)
      StIdle: begin
        w_cnt_d     = '0;
        w_bit_idx_d = 3'd0;
        if (!r_rx_s) begin
          w_state_d = StStart;
        end
      end

      StStart: begin
        if (w_cnt_half) begin
          // Mid start bit: a high line here was only a glitch.
          w_cnt_d   = '0;
          w_state_d = r_rx_s ? StIdle : StData;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      StData: begin
        if (w_cnt_wrap) begin
          w_cnt_d   = '0;
          w_shift_d = {r_rx_s, r_shift[7:1]};
          if (w_bit_term) begin
            w_bit_idx_d = 3'd0;
            w_state_d   = StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      StStop: begin
        if (w_cnt_wrap) begin
          w_cnt_d = '0;
          if (r_rx_s) begin
            w_data_d  = r_shift;
            w_valid_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_frame_err_d = 1'b1;
            w_state_d     = StBreak;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      StBreak: begin
        // Wait for the line to return high so a held-low line cannot start a frame.
        w_cnt_d = '0;
        if (r_rx_s) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d   = StIdle;
        w_cnt_d     = '0;
        w_bit_idx_d = 3'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_shift     <= w_shift_d;
      r_data      <= w_data_d;
      r_valid     <= w_valid_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != StIdle);

endmodule
